// File: rtl/key_step_input.sv
// Push-button front end: synchronises and debounces key[1:0], turns key 0 into a
// single-step pulse with auto-repeat and key 1 into a wrapping display page index.
module key_step_input #(
  parameter int DEB_CYC    = 1_000_000,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int PAGES      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key,
  output logic       start,
  output logic [2:0] page,
  output logic [1:0] key_db
);

  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int RW   = $clog2(RMAX + 1);

  // The toggle fires on the edge where the count would reach DEB_CYC-1, so the
  // debounced level moves DEB_CYC-1 edges after the synchronised level changes.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 2);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);
  localparam logic [2:0]    PAGE_LAST = 3'(PAGES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [1:0]    sync1_reg, sync2_reg;
  logic [1:0]    db;
  logic [1:0]    db_d_reg;
  logic [1:0]    lvl;
  logic [1:0]    pe;
  state_t        state_reg;
  logic [RW-1:0] rcnt_reg;
  logic          start_reg;
  logic [2:0]    page_reg;

  assign lvl    = ~sync2_reg;
  assign pe     = db & ~db_d_reg;
  assign key_db = db;
  assign start  = start_reg;
  assign page   = page_reg;

  // Released buttons read as 1, so the synchroniser presets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
      db_d_reg  <= 2'b00;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
      db_d_reg  <= db;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [DW-1:0] dcnt_reg;
      logic          db_bit_reg;

      assign db[gi] = db_bit_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          dcnt_reg   <= '0;
          db_bit_reg <= 1'b0;
        end else if (lvl[gi] == db_bit_reg) begin
          dcnt_reg <= '0;
        end else if (dcnt_reg == DEB_LAST) begin
          db_bit_reg <= ~db_bit_reg;
          dcnt_reg   <= '0;
        end else begin
          dcnt_reg <= dcnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  // Key 0 step/auto-repeat machine and key 1 page counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rcnt_reg  <= '0;
      start_reg <= 1'b0;
      page_reg  <= 3'd0;
    end else begin
      start_reg <= 1'b0;

      if (pe[1]) begin
        page_reg <= (page_reg == PAGE_LAST) ? 3'd0 : page_reg + 3'd1;
      end

      case (state_reg)
        IDLE: begin
          if (pe[0]) begin
            start_reg <= 1'b1;
            rcnt_reg  <= '0;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (!db[0]) begin
            state_reg <= IDLE;
          end else if (rcnt_reg == HOLD_LAST) begin
            start_reg <= 1'b1;
            rcnt_reg  <= '0;
            state_reg <= REPEAT;
          end else begin
            rcnt_reg <= rcnt_reg + 1'b1;
          end
        end
        REPEAT: begin
          // A release in the same cycle as a terminal count wins: no pulse.
          if (!db[0]) begin
            state_reg <= IDLE;
          end else if (rcnt_reg == REP_LAST) begin
            start_reg <= 1'b1;
            rcnt_reg  <= '0;
          end else begin
            rcnt_reg <= rcnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_step_input.sv
// Bench for key_step_input: directed scenarios plus random key/reset traffic,
// compared every cycle against a timing-level behavioural model.
module tb_key_step_input;

  localparam int DEB   = 4;
  localparam int HOLD  = 20;
  localparam int REP   = 8;
  localparam int PAGES = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic       start;
  logic [2:0] page;
  logic [1:0] key_db;

  key_step_input #(
    .DEB_CYC   (DEB),
    .HOLD_CYC  (HOLD),
    .REPEAT_CYC(REP),
    .PAGES     (PAGES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .start (start),
    .page  (page),
    .key_db(key_db)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses[$];

  // Model state: synchroniser stages, accepted levels, disagreement run lengths,
  // and the time of the last key-0 press for repeat arithmetic.
  logic [1:0] m_s1, m_s2, m_db, m_dbp;
  int         m_run[2];
  bit         m_active;
  int         m_t;
  logic       m_start;
  int         m_page;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11; m_db = 2'b00; m_dbp = 2'b00;
    m_run[0] = 0; m_run[1] = 0;
    m_active = 1'b0; m_t = 0; m_start = 1'b0; m_page = 0;
  endtask

  task automatic step();
    logic [1:0] k, lvl, pe;
    logic       r;
    int         d;
    k = key;
    r = rst;
    @(posedge clk);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      lvl = ~m_s2;
      pe  = m_db & ~m_dbp;
      m_start = 1'b0;
      if (!m_active) begin
        if (pe[0]) begin
          m_start = 1'b1; m_active = 1'b1; m_t = cyc;
        end
      end else if (!m_db[0]) begin
        m_active = 1'b0;
      end else begin
        d = cyc - m_t;
        if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) m_start = 1'b1;
      end
      if (pe[1]) m_page = (m_page + 1) % PAGES;
      m_dbp = m_db;
      for (int i = 0; i < 2; i++) begin
        if (lvl[i] == m_db[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB - 1) begin
            m_db[i] = ~m_db[i];
            m_run[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = k;
    end
    #1;
    chk("start", 8'(start), 8'(m_start));
    chk("page", 8'(page), 8'(m_page));
    chk("key_db", 8'(key_db), 8'(m_db));
    if (start === 1'b1) pulses.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int c0;
  int found;

  initial begin
    model_reset();
    rst = 1'b1;
    key = 2'b00;

    // Reset with both keys held, then re-debounce after release.
    run(3);
    chk("rst_start", 8'(start), 8'h00);
    chk("rst_page", 8'(page), 8'h00);
    rst = 1'b0;
    pulses.delete();
    run(5);
    chk("rst_kdb_5", 8'(key_db), 8'h03);
    run(1);
    chk("rst_page1", 8'(page), 8'h01);
    chk("rst_one_start", 8'(pulses.size()), 8'h01);
    key = 2'b11;
    run(20);

    // Bounce rejection on key 0.
    pulses.delete();
    for (int i = 0; i < 30; i++) begin
      key[0] = (i % 4) < 2;
      step();
    end
    key = 2'b11;
    run(10);
    chk("bounce_no_start", 8'(pulses.size()), 8'h00);
    chk("bounce_kdb0", 8'(key_db[0]), 8'h00);

    // Single short press.
    pulses.delete();
    c0 = cyc;
    key[0] = 1'b0;
    run(15);
    key[0] = 1'b1;
    run(30);
    chk("single_count", 8'(pulses.size()), 8'h01);
    if (pulses.size() > 0) chk("single_lat", 8'(pulses[0] - c0), 8'd6);

    // Long press with auto-repeat; release lands on a terminal count.
    pulses.delete();
    key[0] = 1'b0;
    run(60);
    key[0] = 1'b1;
    run(40);
    chk("rep_count", 8'(pulses.size()), 8'd6);
    if (pulses.size() >= 4) begin
      chk("rep_1", 8'(pulses[1] - pulses[0]), 8'd20);
      chk("rep_2", 8'(pulses[2] - pulses[0]), 8'd28);
      chk("rep_3", 8'(pulses[3] - pulses[0]), 8'd36);
    end

    // Page wrap from a fresh reset.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(4);
    pulses.delete();
    for (int p = 0; p < 6; p++) begin
      key[1] = 1'b0;
      run(8);
      key[1] = 1'b1;
      run(8);
      chk("wrap_page", 8'(page), 8'((p + 1) % PAGES));
    end
    chk("wrap_no_start", 8'(pulses.size()), 8'h00);

    // Simultaneous press, then reset while held.
    c0 = cyc;
    key = 2'b00;
    run(6);
    chk("sim_start", 8'(start), 8'h01);
    chk("sim_page", 8'(page), 8'h02);
    run(5);
    rst = 1'b1;
    run(2);
    chk("sim_rst_page", 8'(page), 8'h00);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      step();
      if (start === 1'b1) found = 1;
    end
    chk("sim_restart_seen", 8'(found), 8'h01);
    chk("sim_restart_page", 8'(page), 8'h01);
    key = 2'b11;
    run(15);

    // Random key activity with occasional resets.
    for (int n = 0; n < 120; n++) begin
      key = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 30) == 0);
      run($urandom_range(1, 14));
      rst = 1'b0;
    end
    key = 2'b11;
    run(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
